// File: rtl/load_store_unit.sv
// Load/store unit: one handshaked data-memory transaction per core request, with load extension.
// Optional LSU_MISALIGN_CHECK_EN: misaligned H/W accesses complete locally with misalign_o instead.
module load_store_unit #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BUS_ADDR_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [2:0]                funct3_i,
  input  logic [DATA_WIDTH-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  output logic                      stall_o,
  output logic                      done_o,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic                      misalign_o,
  output logic                      bus_req_o,
  output logic                      bus_we_o,
  output logic [BUS_ADDR_WIDTH-1:0] bus_addr_o,
  output logic [3:0]                bus_be_o,
  output logic [31:0]               bus_wdata_o,
  input  logic                      bus_gnt_i,
  input  logic                      bus_rvalid_i,
  input  logic [31:0]               bus_rdata_i
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e                    r_state;
  logic                      r_done;
  logic [DATA_WIDTH-1:0]     r_rdata;
  logic                      r_bus_req;
  logic                      r_we;
  logic [BUS_ADDR_WIDTH-1:0] r_bus_addr;
  logic [3:0]                r_be;
  logic [31:0]               r_wdata;
  logic [2:0]                r_funct3;
  logic [1:0]                r_lane;

  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_misalign;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata_i[31:0];
    case (funct3_i)
      3'b000, 3'b100: begin
        w_be    = 4'b0001 << addr_i[1:0];
        w_wdata = {4{wdata_i[7:0]}};
      end
      3'b001, 3'b101: begin
        w_be    = addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  logic r_misalign;

  always_comb begin
    w_misalign = 1'b0;
    case (funct3_i)
      3'b000, 3'b100: w_misalign = 1'b0;
      3'b001, 3'b101: w_misalign = addr_i[0];
      default:        w_misalign = (addr_i[1:0] != 2'b00);
    endcase
  end

  assign misalign_o = r_misalign;
`else
  assign w_misalign = 1'b0;
  assign misalign_o = 1'b0;
`endif

  function automatic logic [31:0] f_ext(input logic [2:0]  f3,
                                        input logic [1:0]  lane,
                                        input logic [31:0] word);
    logic [7:0]  v_b;
    logic [15:0] v_h;
    logic [31:0] v_r;
    case (lane)
      2'd0:    v_b = word[7:0];
      2'd1:    v_b = word[15:8];
      2'd2:    v_b = word[23:16];
      default: v_b = word[31:24];
    endcase
    v_h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  v_r = {{24{v_b[7]}}, v_b};
      3'b100:  v_r = {24'b0, v_b};
      3'b001:  v_r = {{16{v_h[15]}}, v_h};
      3'b101:  v_r = {16'b0, v_h};
      default: v_r = word;
    endcase
    return v_r;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= StIdle;
      r_done     <= 1'b0;
      r_rdata    <= '0;
      r_bus_req  <= 1'b0;
      r_we       <= 1'b0;
      r_bus_addr <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_funct3   <= '0;
      r_lane     <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
      r_misalign <= 1'b0;
`endif
      case (r_state)
        StIdle: begin
          // done_o high means the core advances this cycle; its req_i is stale.
          if (req_i && !r_done) begin
            r_we       <= we_i;
            r_funct3   <= funct3_i;
            r_lane     <= addr_i[1:0];
            r_bus_addr <= BUS_ADDR_WIDTH'({addr_i[DATA_WIDTH-1:2], 2'b00});
            r_be       <= w_be;
            r_wdata    <= w_wdata;
            if (w_misalign) begin
              r_done <= 1'b1;
`ifdef LSU_MISALIGN_CHECK_EN
              r_misalign <= 1'b1;
`endif
            end else begin
              r_bus_req <= 1'b1;
              r_state   <= StReq;
            end
          end
        end
        StReq: begin
          if (bus_gnt_i) begin
            r_bus_req <= 1'b0;
            if (r_we) begin
              r_done  <= 1'b1;
              r_state <= StIdle;
            end else begin
              r_state <= StWait;
            end
          end
        end
        StWait: begin
          if (bus_rvalid_i) begin
            r_rdata <= DATA_WIDTH'(f_ext(r_funct3, r_lane, bus_rdata_i));
            r_done  <= 1'b1;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign stall_o     = (r_state != StIdle) | (req_i & ~r_done);
  assign done_o      = r_done;
  assign rdata_o     = r_rdata;
  assign bus_req_o   = r_bus_req;
  assign bus_we_o    = r_we;
  assign bus_addr_o  = r_bus_addr;
  assign bus_be_o    = r_be;
  assign bus_wdata_o = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: transaction-level model plus per-cycle output comparison.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i, we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, done_o, misalign_o;
  logic [31:0] rdata_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  load_store_unit #(.DATA_WIDTH(32), .BUS_ADDR_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o), .done_o(done_o),
    .rdata_o(rdata_o), .misalign_o(misalign_o), .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  // Expected outputs for the current cycle, written by the driver.
  logic        e_stall, e_done, e_breq, e_we, e_mis;
  logic [31:0] e_addr, e_wdata, m_rdata;
  logic [3:0]  e_be;

  // DUT observations per transaction.
  int          mon_cyc, mon_done_cyc, mon_stall;
  logic [3:0]  mon_be;
  logic [31:0] mon_addr, mon_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_be(input logic [2:0] f, input logic [31:0] a);
    int lane;
    lane = int'(a[1:0]);
    case (f)
      3'd0, 3'd4: return 4'(1 << lane);
      3'd1, 3'd5: return 4'(3 << (2 * (lane / 2)));
      default:    return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f, input logic [31:0] d);
    case (f)
      3'd0, 3'd4: return {24'b0, d[7:0]} * 32'h01010101;
      3'd1, 3'd5: return {16'b0, d[15:0]} * 32'h00010001;
      default:    return d;
    endcase
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] w);
    int lane;
    logic [31:0] v;
    lane = int'(a[1:0]);
    case (f)
      3'd0, 3'd4: begin
        v = (w >> (8 * lane)) & 32'hFF;
        if (f == 3'd0 && v >= 32'd128) v = v + 32'hFFFFFF00;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * (lane / 2))) & 32'hFFFF;
        if (f == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic m_mis(input logic [2:0] f, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
    case (f)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return a[0];
      default:    return a[1:0] != 2'b00;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall_o", 32'(stall_o), 32'(e_stall));
      check("done_o", 32'(done_o), 32'(e_done));
      check("misalign_o", 32'(misalign_o), 32'(e_mis));
      check("bus_req_o", 32'(bus_req_o), 32'(e_breq));
      check("rdata_o", rdata_o, m_rdata);
      if (e_breq) begin
        check("bus_we_o", 32'(bus_we_o), 32'(e_we));
        check("bus_addr_o", bus_addr_o, e_addr);
        check("bus_be_o", 32'(bus_be_o), 32'(e_be));
        if (e_we) check("bus_wdata_o", bus_wdata_o, e_wdata);
      end
      if (bus_req_o) begin
        mon_be    = bus_be_o;
        mon_addr  = bus_addr_o;
        mon_wdata = bus_wdata_o;
      end
      if (done_o && mon_done_cyc < 0) mon_done_cyc = mon_cyc;
      if (stall_o && mon_cyc > 0) mon_stall++;
      mon_cyc++;
    end
  end

  task automatic set_idle();
    e_stall = 1'b0; e_done = 1'b0; e_breq = 1'b0; e_mis = 1'b0;
  endtask

  // Drives one transaction: grant after gd extra cycles, rvalid rd cycles into WAIT.
  task automatic txn(input logic we, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d, input int gd, input int rd,
                     input logic [31:0] word);
    @(posedge clk); #1;
    req_i = 1'b1; we_i = we; funct3_i = f; addr_i = a; wdata_i = d;
    mon_cyc = 0; mon_done_cyc = -1; mon_stall = 0;
    mon_be = 4'h0; mon_addr = 32'h0; mon_wdata = 32'h0;
    e_stall = 1'b1; e_done = 1'b0; e_breq = 1'b0; e_mis = 1'b0;
    e_we = we; e_addr = {a[31:2], 2'b00}; e_be = m_be(f, a); e_wdata = m_wd(f, d);
    if (m_mis(f, a)) begin
      @(posedge clk); #1;
      e_done = 1'b1; e_mis = 1'b1; e_stall = 1'b0;
    end else begin
      for (int k = 0; k <= gd; k++) begin
        @(posedge clk); #1;
        e_breq = 1'b1; e_stall = 1'b1; bus_gnt_i = (k == gd);
      end
      @(posedge clk); #1;
      bus_gnt_i = 1'b0; e_breq = 1'b0;
      if (!we) begin
        for (int k = 0; k <= rd; k++) begin
          if (k > 0) begin
            @(posedge clk); #1;
          end
          e_stall = 1'b1;
          bus_rvalid_i = (k == rd);
          bus_rdata_i = (k == rd) ? word : 32'h55AA55AA;
        end
        @(posedge clk); #1;
        bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
        m_rdata = m_ld(f, a, word);
      end
      e_done = 1'b1; e_stall = 1'b0;
    end
    @(posedge clk); #1;
    req_i = 1'b0;
    set_idle();
  endtask

  initial begin
    rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; funct3_i = 3'd0; addr_i = 32'h0;
    wdata_i = 32'h0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
    set_idle(); e_we = 1'b0; e_addr = 32'h0; e_wdata = 32'h0; e_be = 4'h0; m_rdata = 32'h0;
    mon_cyc = 0; mon_done_cyc = -1; mon_stall = 0;
    #2;
    check("rst_stall", 32'(stall_o), 32'h0);
    check("rst_done", 32'(done_o), 32'h0);
    check("rst_bus_req", 32'(bus_req_o), 32'h0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_be", 32'(bus_be_o), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
    check("sw_done_cycle", 32'(mon_done_cyc), 32'd2);
    check("sw_stall_cycles", 32'(mon_stall), 32'd1);
    check("sw_be", 32'(mon_be), 32'hF);
    check("sw_addr", mon_addr, 32'h100);

    txn(1'b0, 3'b000, 32'h203, 32'h0, 2, 1, 32'h80000000);
    check("lb_rdata", rdata_o, 32'hFFFFFF80);
    check("lb_done_cycle", 32'(mon_done_cyc), 32'd6);
    check("lb_stall_cycles", 32'(mon_stall), 32'd5);
    txn(1'b0, 3'b100, 32'h203, 32'h0, 2, 1, 32'h80000000);
    check("lbu_rdata", rdata_o, 32'h00000080);

    txn(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 0, 0, 32'h0);
    check("sh_be", 32'(mon_be), 32'hC);
    check("sh_wdata", mon_wdata, 32'hABCDABCD);
    check("sh_keeps_rdata", rdata_o, 32'h00000080);

    txn(1'b0, 3'b101, 32'h002, 32'h0, 0, 0, 32'h1234F00D);
    check("lhu_rdata", rdata_o, 32'h00001234);
    check("lhu_done_cycle", 32'(mon_done_cyc), 32'd3);
    txn(1'b0, 3'b001, 32'h000, 32'h0, 0, 0, 32'h1234F00D);
    check("lh_rdata", rdata_o, 32'hFFFFF00D);

    txn(1'b1, 3'b000, 32'h003, 32'h000000A5, 1, 0, 32'h0);
    check("sb_be", 32'(mon_be), 32'h8);
    check("sb_wdata", mon_wdata, 32'hA5A5A5A5);
    txn(1'b0, 3'b110, 32'h104, 32'h0, 0, 2, 32'h11223344);
    check("lw110_rdata", rdata_o, 32'h11223344);

    // Abort a load in WAIT with an asynchronous reset.
    @(posedge clk); #1;
    req_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h300;
    e_stall = 1'b1; e_we = 1'b0; e_addr = 32'h300; e_be = 4'hF;
    @(posedge clk); #1;
    e_breq = 1'b1; bus_gnt_i = 1'b1;
    @(posedge clk); #1;
    bus_gnt_i = 1'b0; e_breq = 1'b0;
    chk_en = 1'b0;
    #2;
    rst_n = 1'b0; req_i = 1'b0;
    #1;
    check("arst_bus_req", 32'(bus_req_o), 32'h0);
    check("arst_stall", 32'(stall_o), 32'h0);
    check("arst_rdata", rdata_o, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
    @(negedge clk);
    check("late_rvalid_done", 32'(done_o), 32'h0);
    check("late_rvalid_rdata", rdata_o, 32'h0);
    check("late_rvalid_stall", 32'(stall_o), 32'h0);
    m_rdata = 32'h0; set_idle();
    chk_en = 1'b1;
    txn(1'b0, 3'b010, 32'h300, 32'h0, 0, 0, 32'h0BADF00D);
    check("post_rst_lw", rdata_o, 32'h0BADF00D);

    txn(1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'hCAFEF00D);
`ifdef LSU_MISALIGN_CHECK_EN
    check("mis_done_cycle", 32'(mon_done_cyc), 32'd1);
    check("mis_no_bus", mon_addr, 32'h0);
    check("mis_rdata_kept", rdata_o, 32'h0BADF00D);
`else
    check("lw101_addr", mon_addr, 32'h100);
    check("lw101_rdata", rdata_o, 32'hCAFEF00D);
`endif

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
